// File: rtl/hc165_pkg.sv
// -----------------------------------------------------------------------------
// hc165_pkg
//   Shared definitions for the 74HC165 serial status reader:
//     - state_e      : read-controller FSM states
//     - N_BITS_DEF   : default chain length in bits
//     - DIV_DEF      : default i_clk cycles per serial phase
//     - clog2()      : constant-evaluable ceiling log2 used for counter widths
// -----------------------------------------------------------------------------
package hc165_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOW    = 3'd3,
        ST_HIGH   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int N_BITS_DEF = 16;
    localparam int DIV_DEF    = 2;

    // ceil(log2(v)); clog2(1) = 0, clog2(2) = 1, clog2(17) = 5.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hc165_phase_tick.sv
// -----------------------------------------------------------------------------
// hc165_phase_tick
//   DIV-cycle phase timer. phase_last_o is high on the last cycle of each
//   DIV-cycle phase. The count restarts from zero whenever restart_i is high
//   (the controller raises it on every state change), so each new state sees
//   a full DIV-cycle phase.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   restart_i    force the count back to zero on the next edge
//   phase_last_o high during the final cycle of the current phase
// -----------------------------------------------------------------------------
module hc165_phase_tick
    import hc165_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic phase_last_o
);

    localparam int             CW       = clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_last_o = (cnt_q == CNT_LAST);

    // Wrapping at DIV-1 keeps the counter inside [0, DIV-1] even for
    // non-power-of-two DIV.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || phase_last_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hc165_read_ctrl.sv
// -----------------------------------------------------------------------------
// hc165_read_ctrl
//   Serial status reader driving a daisy-chained 74HC165 PISO chain. Each scan
//   parallel-loads the chain, then clocks N_BITS bits out of QH into a shift
//   register (first bit lands in the MSB) and publishes them on o_data with a
//   one-cycle o_valid strobe and an o_changed flag. Scans are started by
//   i_start or repeat back-to-back while i_auto_en is high.
//
//   Scan timeline (each phase DIV cycles):
//     LOAD, SETTLE, LOW, (HIGH, LOW) x (N_BITS-1), DONE (1 cycle)
//   o_valid rises DIV*(2*N_BITS+1)+1 cycles after the trigger edge.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_start    single-scan request (dropped while busy or in DONE)
//   i_auto_en  continuous scanning while high
//   i_QH       serial data from the last 74HC165
//   o_SH_LD_n  74HC165 shift/load-n (0 = parallel load)
//   o_CLK      74HC165 shift clock
//   o_CLK_INH  74HC165 clock inhibit (1 = inhibit)
//   o_data     last completed scan
//   o_valid    one-cycle strobe when o_data updates
//   o_changed  one-cycle strobe with o_valid when o_data changed
//   o_busy     scan in progress
// -----------------------------------------------------------------------------
module hc165_read_ctrl
    import hc165_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int DIV    = DIV_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_auto_en,
    input  logic              i_QH,
    output logic              o_SH_LD_n,
    output logic              o_CLK,
    output logic              o_CLK_INH,
    output logic [N_BITS-1:0] o_data,
    output logic              o_valid,
    output logic              o_changed,
    output logic              o_busy
);

    localparam int             BCW      = clog2(N_BITS + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(N_BITS);

    state_e            state_q;
    state_e            state_d;
    logic [BCW-1:0]    bit_cnt_q;
    logic [BCW-1:0]    bit_cnt_d;
    logic [N_BITS-1:0] shift_q;
    logic [N_BITS-1:0] shift_d;
    logic [N_BITS-1:0] data_q;
    logic [N_BITS-1:0] data_d;
    logic              qh_q;
    logic              valid_q;
    logic              valid_d;
    logic              changed_q;
    logic              changed_d;
    logic              busy_q;
    logic              busy_d;
    logic              sh_ld_n_q;
    logic              sh_ld_n_d;
    logic              clk_q;
    logic              clk_d;
    logic              clk_inh_q;
    logic              clk_inh_d;

    logic              phase_last;
    logic              state_chg;

    assign state_chg = (state_d != state_q);

    hc165_phase_tick #(
        .DIV (DIV)
    ) u_phase_tick (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .restart_i    (state_chg),
        .phase_last_o (phase_last)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // i_start and i_auto_en together still produce one scan.
                if (i_start || i_auto_en) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Discard anything left from a previous scan.
                bit_cnt_d = '0;
                shift_d   = '0;
                if (phase_last) begin
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (phase_last) begin
                    state_d = ST_LOW;
                end
            end

            ST_LOW: begin
                // Sample at the end of the low phase, when QH has had a full
                // phase to settle after the previous rising edge.
                if (phase_last) begin
                    shift_d   = {shift_q[N_BITS-2:0], qh_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
            end

            ST_HIGH: begin
                if (phase_last) begin
                    state_d = ST_LOW;
                end
            end

            ST_DONE: begin
                // Single cycle; i_start here is deliberately ignored.
                data_d    = shift_q;
                valid_d   = 1'b1;
                changed_d = (shift_q != data_q);
                if (i_auto_en) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin and status flops are computed from the next state so that they
    // line up with state_q while still coming straight out of a flop.
    always_comb begin
        sh_ld_n_d = (state_d != ST_LOAD);
        clk_d     = (state_d == ST_HIGH);
        clk_inh_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                    (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            qh_q      <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
            sh_ld_n_q <= 1'b1;
            clk_q     <= 1'b0;
            clk_inh_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            qh_q      <= i_QH;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
            sh_ld_n_q <= sh_ld_n_d;
            clk_q     <= clk_d;
            clk_inh_q <= clk_inh_d;
        end
    end

    assign o_SH_LD_n = sh_ld_n_q;
    assign o_CLK     = clk_q;
    assign o_CLK_INH = clk_inh_q;
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_changed = changed_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_hc165_read_ctrl.sv
module tb_hc165_read_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: N_BITS=16, DIV=2 ----------------
    logic        start1 = 1'b0;
    logic        auto1  = 1'b0;
    logic        qh1;
    logic        sh_ld_n1, sclk1, inh1, v1, ch1, busy1;
    logic [15:0] data1;

    hc165_read_ctrl #(.N_BITS(16), .DIV(2)) u_dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start1),
        .i_auto_en (auto1),
        .i_QH      (qh1),
        .o_SH_LD_n (sh_ld_n1),
        .o_CLK     (sclk1),
        .o_CLK_INH (inh1),
        .o_data    (data1),
        .o_valid   (v1),
        .o_changed (ch1),
        .o_busy    (busy1)
    );

    // ---------------- DUT 2: N_BITS=8, DIV=3 ----------------
    logic        start2 = 1'b0;
    logic        auto2  = 1'b0;
    logic        qh2;
    logic        sh_ld_n2, sclk2, inh2, v2, ch2, busy2;
    logic [7:0]  data2;

    hc165_read_ctrl #(.N_BITS(8), .DIV(3)) u_dut2 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start2),
        .i_auto_en (auto2),
        .i_QH      (qh2),
        .o_SH_LD_n (sh_ld_n2),
        .o_CLK     (sclk2),
        .o_CLK_INH (inh2),
        .o_data    (data2),
        .o_valid   (v2),
        .o_changed (ch2),
        .o_busy    (busy2)
    );

    // ---------------- 74HC165 chain models ----------------
    // Parallel load while SH/LD_n low; shift toward QH on rising CLK when
    // not inhibited. Serial input of the first chip tied low.
    logic [15:0] par1 = 16'h0000;
    logic [15:0] sr1  = 16'h0000;
    always @(posedge sclk1 or negedge sh_ld_n1) begin
        if (!sh_ld_n1)  sr1 <= par1;
        else if (!inh1) sr1 <= {sr1[14:0], 1'b0};
    end
    assign qh1 = sr1[15];

    logic [7:0] par2 = 8'h00;
    logic [7:0] sr2  = 8'h00;
    always @(posedge sclk2 or negedge sh_ld_n2) begin
        if (!sh_ld_n2)  sr2 <= par2;
        else if (!inh2) sr2 <= {sr2[6:0], 1'b0};
    end
    assign qh2 = sr2[7];

    // ---------------- monitors (monotonic; bench takes snapshots) ----------------
    int rise1 = 0;
    int ld1   = 0;
    int vc1   = 0;
    always @(posedge sclk1) rise1++;
    always @(negedge clk) begin
        if (!sh_ld_n1) ld1++;
        if (v1)        vc1++;
    end

    // DUT2 serial clock phase lengths.
    int   nhi2 = 0;
    int   nlo2 = 0;
    int   bad2 = 0;
    int   run2 = 0;
    logic prev2 = 1'b0;
    bit   had_fall2 = 1'b0;
    always @(negedge clk) begin
        if (inh2) had_fall2 = 1'b0;
        if (sclk2 !== prev2) begin
            if (prev2) begin
                nhi2++;
                if (run2 != 3) bad2++;
                had_fall2 = 1'b1;
            end else if (had_fall2) begin
                nlo2++;
                if (run2 != 3) bad2++;
            end
            run2 = 1;
        end else begin
            run2++;
        end
        prev2 = sclk2;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse i_start for one cycle; returns 1 time unit after the sampling edge.
    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Count edges until o_valid is seen; -1 if it never comes.
    task automatic wait_valid(input bit sel, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (sel ? v2 : v1) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int cyc;
    int r0, l0, vs0, h0, lo0, b0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sh_ld_n", sh_ld_n1, 1);
        check("rst_clk",     sclk1,    0);
        check("rst_clk_inh", inh1,     1);
        check("rst_data",    data1,    0);
        check("rst_valid",   v1,       0);
        check("rst_changed", ch1,      0);
        check("rst_busy",    busy1,    0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 1: single scan of 0xA5C3
        par1 = 16'hA5C3;
        r0 = rise1;
        l0 = ld1;
        pulse_start(0);
        check("t1_busy_on", busy1, 1);
        wait_valid(0, cyc);
        check("t1_latency", cyc,   67);
        check("t1_data",    data1, 16'hA5C3);
        check("t1_changed", ch1,   1);
        check("t1_busy_off", busy1, 0);
        check("t1_clk_rises", rise1 - r0, 15);
        check("t1_load_cycles", ld1 - l0, 2);

        // 2: same value again, stray i_start mid-scan
        repeat (5) @(posedge clk);
        vs0 = vc1;
        pulse_start(0);
        repeat (9) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        wait_valid(0, cyc);
        check("t2_latency", cyc,   57);
        check("t2_data",    data1, 16'hA5C3);
        check("t2_changed", ch1,   0);
        repeat (80) @(posedge clk);
        #1;
        check("t2_valid_count", vc1 - vs0, 1);
        check("t2_busy_idle",   busy1,     0);

        // 3: auto mode, value changes 0x0001 -> 0x8000 during second auto scan
        par1 = 16'h0001;
        pulse_start(0);
        wait_valid(0, cyc);
        check("t3_pre_latency", cyc,   67);
        check("t3_pre_data",    data1, 16'h0001);
        check("t3_pre_changed", ch1,   1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        auto1 = 1'b1;
        @(posedge clk);
        #1;
        wait_valid(0, cyc);
        check("t3_s1_latency", cyc,   67);
        check("t3_s1_data",    data1, 16'h0001);
        check("t3_s1_changed", ch1,   0);
        repeat (20) @(posedge clk);
        #1 par1 = 16'h8000;
        wait_valid(0, cyc);
        check("t3_s2_period",  cyc,   47);
        check("t3_s2_data",    data1, 16'h0001);
        check("t3_s2_changed", ch1,   0);
        wait_valid(0, cyc);
        check("t3_s3_period",  cyc,   67);
        check("t3_s3_data",    data1, 16'h8000);
        check("t3_s3_changed", ch1,   1);
        wait_valid(0, cyc);
        check("t3_s4_period",  cyc,   67);
        check("t3_s4_data",    data1, 16'h8000);
        check("t3_s4_changed", ch1,   0);

        // 6: drop i_auto_en mid-scan; scan finishes, then idle
        repeat (20) @(posedge clk);
        #1 auto1 = 1'b0;
        l0  = ld1;
        vs0 = vc1;
        wait_valid(0, cyc);
        check("t6_last_period", cyc,   47);
        check("t6_last_data",   data1, 16'h8000);
        repeat (100) @(posedge clk);
        #1;
        check("t6_busy_idle",   busy1,     0);
        check("t6_no_reload",   ld1 - l0,  0);
        check("t6_valid_count", vc1 - vs0, 1);

        // 4: reset in the middle of a scan
        par1 = 16'h1234;
        pulse_start(0);
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_clk_inh", inh1,     1);
        check("t4_data",    data1,    0);
        check("t4_busy",    busy1,    0);
        check("t4_sh_ld_n", sh_ld_n1, 1);
        check("t4_clk",     sclk1,    0);
        check("t4_valid",   v1,       0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0  = rise1;
        vs0 = vc1;
        repeat (100) @(posedge clk);
        #1;
        check("t4_no_clk_edges", rise1 - r0, 0);
        check("t4_idle_busy",    busy1,      0);
        check("t4_no_valid",     vc1 - vs0,  0);

        // 5: N_BITS=8, DIV=3 variant with 0x81
        par2 = 8'h81;
        h0  = nhi2;
        lo0 = nlo2;
        b0  = bad2;
        pulse_start(1);
        wait_valid(1, cyc);
        check("t5_latency", cyc,   52);
        check("t5_data",    data2, 8'h81);
        check("t5_changed", ch2,   1);
        check("t5_busy",    busy2, 0);
        check("t5_high_phases", nhi2 - h0,  7);
        check("t5_low_phases",  nlo2 - lo0, 6);
        check("t5_phase_len_bad", bad2 - b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
